// File: rtl/attn_spike_dot_accum_pkg.sv
// Shared constants, output FSM encoding and width helper for the spike dot-product accumulator.
// Latency: n/a (package).
// Backpressure: n/a (package).

`ifndef ATTN_SDA_NUM_GROUPS
`define ATTN_SDA_NUM_GROUPS 4
`endif
`ifndef ATTN_SDA_VEC_BEATS
`define ATTN_SDA_VEC_BEATS 12
`endif
`ifndef ATTN_SDA_ACC_W
`define ATTN_SDA_ACC_W 12
`endif

package attn_spike_dot_accum_pkg;

  // Spikes per popcount group and the width of one group's count (0..8).
  localparam int SPIKE_GRP_W = 8;
  localparam int POPCNT_W    = 4;

  // Default geometry: 4 groups x 8 spikes = 32-bit beat, 12 beats = 384 channels.
  localparam int DEF_NUM_GROUPS = `ATTN_SDA_NUM_GROUPS;
  localparam int DEF_VEC_BEATS  = `ATTN_SDA_VEC_BEATS;
  localparam int DEF_ACC_W      = `ATTN_SDA_ACC_W;

  // Output holding register: EMPTY means o_valid=0, FULL means a result waits for i_ready.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Smallest accumulator width that holds an all-ones dot product without wrapping.
  function automatic int min_acc_w(input int num_groups, input int vec_beats);
    return $clog2(SPIKE_GRP_W * num_groups * vec_beats + 1);
  endfunction

endpackage

// File: rtl/attn_spike_dot_accum_if.sv
// Beat input and result output channels of the spike dot-product accumulator.
// Latency: n/a (wiring only).
// Backpressure: o_ready throttles beats; i_ready throttles results.

interface attn_spike_dot_accum_if #(
  parameter int NUM_GROUPS = attn_spike_dot_accum_pkg::DEF_NUM_GROUPS,
  parameter int ACC_W      = attn_spike_dot_accum_pkg::DEF_ACC_W
);
  import attn_spike_dot_accum_pkg::*;

  // Beat channel (producer -> accumulator).
  logic [SPIKE_GRP_W*NUM_GROUPS-1:0] i_Q_spikes;
  logic [SPIKE_GRP_W*NUM_GROUPS-1:0] i_K_spikes;
  logic                              i_valid;
  logic                              o_ready;

  // Result channel (accumulator -> scaling/LIF stage).
  logic [ACC_W-1:0]                  o_Sum;
  logic                              o_valid;
  logic                              i_ready;

  // The side that feeds beats and consumes results.
  modport master (
    output i_Q_spikes, i_K_spikes, i_valid, i_ready,
    input  o_ready, o_Sum, o_valid
  );

  // The accumulator itself.
  modport slave (
    input  i_Q_spikes, i_K_spikes, i_valid, i_ready,
    output o_ready, o_Sum, o_valid
  );

endinterface

// File: rtl/attn_spike_dot_accum_fa_group.sv
// Counts the set spikes in one 8-spike group (0..8).
// Latency: combinational.
// Backpressure: none.

module attn_spike_dot_accum_fa_group
  import attn_spike_dot_accum_pkg::*;
(
  input  logic [SPIKE_GRP_W-1:0] spikes,
  output logic [POPCNT_W-1:0]    count
);

  // Ripple the spike bits into a small counter; synthesis maps this to a full-adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < SPIKE_GRP_W; i++) begin
      count = count + POPCNT_W'(spikes[i]);
    end
  end

endmodule

// File: rtl/attn_spike_dot_accum.sv
// Q.K^T spike dot product: AND + grouped popcount per beat, summed over VEC_BEATS beats.
// Latency: last beat accepted in cycle t -> o_valid in cycle t+2.
// Backpressure: o_ready drops only while a finished result waits behind an unaccepted one.

module attn_spike_dot_accum #(
  parameter int NUM_GROUPS = attn_spike_dot_accum_pkg::DEF_NUM_GROUPS,
  parameter int VEC_BEATS  = attn_spike_dot_accum_pkg::DEF_VEC_BEATS,
  parameter int ACC_W      = attn_spike_dot_accum_pkg::DEF_ACC_W
) (
  input  logic                    s_clk,
  input  logic                    s_rst,
  attn_spike_dot_accum_if.slave   bus
);
  import attn_spike_dot_accum_pkg::*;

  localparam int                BEAT_W    = SPIKE_GRP_W * NUM_GROUPS;
  localparam int                SUM_W     = $clog2(BEAT_W + 1);
  localparam int                CNT_W     = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(VEC_BEATS - 1);

  // Refuse to build an accumulator that could wrap on an all-ones vector.
  if (ACC_W < min_acc_w(NUM_GROUPS, VEC_BEATS)) begin : g_acc_w_chk
    $error("attn_spike_dot_accum: ACC_W too narrow for NUM_GROUPS*VEC_BEATS spikes");
  end

  logic                  accept;
  logic                  stall;
  logic                  s2_fire;
  logic                  s2_load;
  logic                  last_beat;
  logic                  first_beat;
  logic                  out_full;
  logic [BEAT_W-1:0]     and_word;
  logic [POPCNT_W-1:0]   grp_cnt [NUM_GROUPS];
  logic [SUM_W-1:0]      grp_sum;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_rdy_en;
  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic                  r_s1_first;
  logic [SUM_W-1:0]      r_s1_sum;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      acc_next;
  logic [ACC_W-1:0]      r_sum;
  out_state_t            r_state;
  out_state_t            state_next;

  // ---------------- S0: beat acceptance ----------------
  assign out_full   = (r_state == OUT_FULL);
  // A last beat parked in S1 cannot retire while the previous result is still unclaimed.
  assign stall      = r_s1_valid && r_s1_last && out_full && !bus.i_ready;
  assign bus.o_ready = r_rdy_en && !stall;
  assign accept     = bus.i_valid && bus.o_ready;
  assign last_beat  = (r_beat_cnt == LAST_BEAT);
  assign first_beat = (r_beat_cnt == '0);

  // Hold o_ready low through reset; it rises on the first edge after release.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  // Beat position within the current vector; idle cycles leave it untouched.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_beat_cnt <= '0;
    end else if (accept) begin
      r_beat_cnt <= last_beat ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

  // ---------------- AND + grouped popcount ----------------
  assign and_word = bus.i_Q_spikes & bus.i_K_spikes;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    attn_spike_dot_accum_fa_group u_fa_group (
      .spikes (and_word[g*SPIKE_GRP_W +: SPIKE_GRP_W]),
      .count  (grp_cnt[g])
    );
  end

  // Sum the group counts into the beat's coincidence count (0..BEAT_W).
  always_comb begin
    grp_sum = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp_sum = grp_sum + SUM_W'(grp_cnt[g]);
    end
  end

  // ---------------- S1: register the beat count ----------------
  // Capture the beat count and its position tags; freeze while stalled.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_sum   <= '0;
    end else if (!stall) begin
      r_s1_valid <= accept;
      r_s1_last  <= last_beat;
      r_s1_first <= first_beat;
      r_s1_sum   <= grp_sum;
    end
  end

  // ---------------- S2: accumulate and publish ----------------
  assign s2_fire  = r_s1_valid && !stall;
  assign s2_load  = s2_fire && r_s1_last;
  // Beat 0 of a vector overwrites, so no separate clear of the accumulator is needed.
  assign acc_next = r_s1_first ? ACC_W'(r_s1_sum) : r_acc + ACC_W'(r_s1_sum);

  // Running sum keeps advancing for the next vector even while a result is held.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst)       r_acc <= '0;
    else if (s2_fire) r_acc <= acc_next;
  end

  // Result register; only written on a retiring last beat, so stable while held.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst)       r_sum <= '0;
    else if (s2_load) r_sum <= acc_next;
  end

  // ---------------- Output FSM ----------------
  // State register for the result holding slot.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) r_state <= OUT_EMPTY;
    else        r_state <= state_next;
  end

  // Fill on a retiring last beat; drain on i_ready; a simultaneous drain+fill stays FULL.
  always_comb begin
    state_next = r_state;
    case (r_state)
      OUT_EMPTY: if (s2_load) state_next = OUT_FULL;
      OUT_FULL: begin
        if (s2_load)          state_next = OUT_FULL;
        else if (bus.i_ready) state_next = OUT_EMPTY;
      end
      default:                state_next = OUT_EMPTY;
    endcase
  end

  assign bus.o_valid = out_full;
  assign bus.o_Sum   = r_sum;

endmodule
